// File: rtl/xpb_reduce_sequencer.sv
// xpb_reduce_sequencer
//   Reduces the upper digits of a modular-squaring product through one
//   time-shared xpb ROM port. It captures NUM_DIGITS digits, issues one ROM
//   read per cycle (table = digit position, address = digit value) and sums
//   the returned XPB_W-bit entries into an ACC_W-bit result.
//
// Ports
//   clk       : system clock, rising edge
//   reset     : asynchronous active-high reset
//   start     : request pulse, accepted only while busy=0
//   digits_in : packed digits, digit i = digits_in[i*DIGIT_W +: DIGIT_W]
//   busy      : operation in progress
//   done      : one-cycle pulse; acc_out is valid from this cycle
//   acc_out   : final sum, held until the next done
//   rom_en    : ROM read strobe
//   rom_sel   : xpb table index (digit position)
//   rom_addr  : xpb table address (digit value)
//   rom_data  : ROM read data, valid ROM_LAT cycles after rom_en
module xpb_reduce_sequencer #(
    parameter int NUM_DIGITS = 8,
    parameter int DIGIT_W    = 5,
    parameter int XPB_W      = 1024,
    parameter int ROM_LAT    = 1,
    parameter int SEL_W      = 3,
    parameter int ACC_W      = 1027
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
    output logic                          busy,
    output logic                          done,
    output logic [ACC_W-1:0]              acc_out,
    output logic                          rom_en,
    output logic [SEL_W-1:0]              rom_sel,
    output logic [DIGIT_W-1:0]            rom_addr,
    input  logic [XPB_W-1:0]              rom_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [SEL_W-1:0]   LAST_IDX  = SEL_W'(NUM_DIGITS - 1);
    // Oldest stage of the return-valid pipe; all other bits are still in flight.
    localparam logic [ROM_LAT-1:0] PIPE_HEAD = ROM_LAT'(1) << (ROM_LAT - 1);

    state_t                        state_reg, state_next;
    logic [SEL_W-1:0]              count_reg;
    logic [SEL_W-1:0]              idx_next;
    logic [NUM_DIGITS*DIGIT_W-1:0] digits_reg;
    logic [DIGIT_W-1:0]            digit_at [NUM_DIGITS];
    logic [ROM_LAT-1:0]            pipe_reg;
    logic [ACC_W-1:0]              acc_reg;
    logic [ACC_W-1:0]              acc_sum;
    logic [ACC_W-1:0]              acc_out_reg;
    logic [SEL_W-1:0]              rom_sel_reg;
    logic [DIGIT_W-1:0]            rom_addr_reg;
    logic                          accept;
    logic                          ret_valid;
    logic                          tail_pending;
    logic                          finish;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_at[gi] = digits_reg[gi*DIGIT_W +: DIGIT_W];
        end
    endgenerate

    // A start is taken whenever the block is not busy, including the DONE
    // cycle, which gives back-to-back operation.
    assign accept       = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign idx_next     = count_reg + SEL_W'(1);
    assign ret_valid    = pipe_reg[ROM_LAT-1];
    assign tail_pending = |(pipe_reg & ~PIPE_HEAD);
    // Leaving DRAIN coincides with the last return being summed.
    assign finish       = (state_reg == DRAIN) && !tail_pending;
    assign acc_sum      = acc_reg + (ret_valid ? {{(ACC_W-XPB_W){1'b0}}, rom_data} : '0);

    // Next-state and control outputs.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        rom_en     = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = ISSUE;
            end
            ISSUE: begin
                busy   = 1'b1;
                rom_en = 1'b1;
                if (count_reg == LAST_IDX) state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (!tail_pending) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? ISSUE : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Issue side: counter, latched digits and registered ROM address.
    // rom_sel/rom_addr are loaded one cycle ahead so they line up with rom_en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg    <= '0;
            digits_reg   <= '0;
            rom_sel_reg  <= '0;
            rom_addr_reg <= '0;
        end else if (accept) begin
            count_reg    <= '0;
            digits_reg   <= digits_in;
            rom_sel_reg  <= '0;
            rom_addr_reg <= digits_in[DIGIT_W-1:0];
        end else if (state_reg == ISSUE) begin
            count_reg <= idx_next;
            if (count_reg != LAST_IDX) begin
                rom_sel_reg  <= idx_next;
                rom_addr_reg <= digit_at[idx_next];
            end
        end
    end

    // Return side: valid pipe mirrors the ROM latency so only real returns
    // are summed; clearing it on reset discards reads from an aborted run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_reg    <= '0;
            acc_reg     <= '0;
            acc_out_reg <= '0;
        end else begin
            pipe_reg[0] <= rom_en;
            for (int i = 1; i < ROM_LAT; i++) begin
                pipe_reg[i] <= pipe_reg[i-1];
            end
            acc_reg <= accept ? '0 : acc_sum;
            if (finish) begin
                acc_out_reg <= acc_sum;
            end
        end
    end

    assign acc_out  = acc_out_reg;
    assign rom_sel  = rom_sel_reg;
    assign rom_addr = rom_addr_reg;

endmodule

// File: tb/tb_xpb_reduce_sequencer.sv
module tb_xpb_reduce_sequencer;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 5;
    localparam int XPB_W      = 1024;
    localparam int SEL_W      = 3;
    localparam int ACC_W      = 1027;
    localparam int DW         = NUM_DIGITS * DIGIT_W;
    localparam logic [XPB_W-1:0] JUNK = XPB_W'(64'h3C);

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [DW-1:0]    digits_in;

    logic             busy, done, rom_en;
    logic [ACC_W-1:0] acc_out;
    logic [SEL_W-1:0] rom_sel;
    logic [DIGIT_W-1:0] rom_addr;
    logic [XPB_W-1:0] rom_data;

    logic             busy3, done3, rom_en3;
    logic [ACC_W-1:0] acc_out3;
    logic [SEL_W-1:0] rom_sel3;
    logic [DIGIT_W-1:0] rom_addr3;
    logic [XPB_W-1:0] rom_data3;
    logic [XPB_W-1:0] p0, p1, p2;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int rom_mode = 0;

    int w_done_cyc, w_en, w_n_done;
    logic w_sel_ok, w_hold_ok;
    logic [ACC_W-1:0] w_acc;

    xpb_reduce_sequencer #(.ROM_LAT(1)) dut (
        .clk(clk), .reset(reset), .start(start), .digits_in(digits_in),
        .busy(busy), .done(done), .acc_out(acc_out), .rom_en(rom_en),
        .rom_sel(rom_sel), .rom_addr(rom_addr), .rom_data(rom_data)
    );

    xpb_reduce_sequencer #(.ROM_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .digits_in(digits_in),
        .busy(busy3), .done(done3), .acc_out(acc_out3), .rom_en(rom_en3),
        .rom_sel(rom_sel3), .rom_addr(rom_addr3), .rom_data(rom_data3)
    );

    always #5 clk = ~clk;

    function automatic logic [XPB_W-1:0] rom_fn(input logic [SEL_W-1:0] s, input logic [DIGIT_W-1:0] a);
        case (rom_mode)
            0:       return XPB_W'((int'(s) + 1) * int'(a));
            1:       return {XPB_W{1'b1}};
            default: return XPB_W'(a);
        endcase
    endfunction

    // ROM models: data valid exactly ROM_LAT cycles after rom_en, junk otherwise.
    always @(posedge clk) begin
        rom_data <= rom_en ? rom_fn(rom_sel, rom_addr) : JUNK;
        p0 <= rom_en3 ? rom_fn(rom_sel3, rom_addr3) : JUNK;
        p1 <= p0;
        p2 <= p1;
    end
    assign rom_data3 = p2;

    task automatic check(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed hi=%h lo=%h, expected hi=%h lo=%h", tag,
                   obs[ACC_W-1:ACC_W-32], obs[63:0], exp[ACC_W-1:ACC_W-32], exp[63:0]);
        end
    endtask

    function automatic logic [DW-1:0] all_digits(input logic [DIGIT_W-1:0] v);
        return {NUM_DIGITS{v}};
    endfunction

    function automatic logic [DW-1:0] seq_digits();
        logic [DW-1:0] d;
        for (int i = 0; i < NUM_DIGITS; i++) d[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(i);
        return d;
    endfunction

    // Start pulse sampled at the edge ending cycle 0; returns in cycle 1.
    // digits_in is scrambled afterwards: it must have no effect.
    task automatic launch(input logic [DW-1:0] d);
        repeat (4) @(negedge clk);
        start = 1'b1;
        digits_in = d;
        @(negedge clk);
        start = 1'b0;
        digits_in = ~d;
        cyc = 1;
    endtask

    task automatic watch(input int max_cyc, input int spam_a, input int spam_b, input logic [ACC_W-1:0] hold);
        w_done_cyc = -1; w_en = 0; w_n_done = 0; w_sel_ok = 1'b1; w_hold_ok = 1'b1; w_acc = '0;
        while (cyc <= max_cyc) begin
            if (rom_en === 1'b1) begin
                if (rom_sel !== SEL_W'(w_en)) w_sel_ok = 1'b0;
                w_en++;
            end
            if (done === 1'b1) begin
                if (w_n_done == 0) begin
                    w_done_cyc = cyc;
                    w_acc = acc_out;
                end
                w_n_done++;
            end else if (w_n_done == 0 && acc_out !== hold) begin
                w_hold_ok = 1'b0;
            end
            if (cyc == spam_a || cyc == spam_b) begin
                start = 1'b1;
                digits_in = all_digits(5'h1F);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    int d3_cyc, d_cyc, n_done_rst;
    logic [ACC_W-1:0] d3_acc, d_acc, maxv;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        digits_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_acc", acc_out, 0);
        check("rst_rom_en", rom_en, 0);
        check("rst_rom_sel", rom_sel, 0);
        check("rst_rom_addr", rom_addr, 0);
        reset = 1'b0;
        $display("step: reset checked");

        // Sum check: (sel+1)*31 summed over sel 0..7 = 31*36.
        rom_mode = 0;
        launch(all_digits(5'h1F));
        watch(10, -1, -1, 0);
        check("sum_done_cyc", w_done_cyc, 10);
        check("sum_acc", w_acc, 1116);
        check("sum_en_cnt", w_en, 8);
        check("sum_sel_order", w_sel_ok, 1);
        check("sum_n_done", w_n_done, 1);
        check("sum_hold", w_hold_ok, 1);
        $display("step: sum acc=%0d done_cyc=%0d", w_acc[31:0], w_done_cyc);

        // Zero digits.
        launch('0);
        watch(10, -1, -1, 1116);
        check("zero_done_cyc", w_done_cyc, 10);
        check("zero_acc", w_acc, 0);
        check("zero_hold", w_hold_ok, 1);
        $display("step: zero acc=%0d done_cyc=%0d", w_acc[31:0], w_done_cyc);

        // Max entries: 8*(2^1024-1) = 2^1027-8.
        rom_mode = 1;
        maxv = {ACC_W{1'b1}} << 3;
        launch(all_digits(5'h0A));
        watch(10, -1, -1, 0);
        check("max_done_cyc", w_done_cyc, 10);
        check("max_acc", w_acc, maxv);
        check("max_bit1026", w_acc[ACC_W-1], 1);
        $display("step: max top=%h done_cyc=%0d", w_acc[ACC_W-1:ACC_W-8], w_done_cyc);

        // ROM_LAT=3 instance, digit i = i, rom_data = addr -> 28 at cycle 12.
        rom_mode = 2;
        launch(seq_digits());
        d3_cyc = -1; d_cyc = -1; d3_acc = '0; d_acc = '0;
        while (cyc <= 14) begin
            if (done3 === 1'b1 && d3_cyc < 0) begin d3_cyc = cyc; d3_acc = acc_out3; end
            if (done === 1'b1 && d_cyc < 0) begin d_cyc = cyc; d_acc = acc_out; end
            @(negedge clk);
            cyc++;
        end
        check("lat3_done_cyc", d3_cyc, 12);
        check("lat3_acc", d3_acc, 28);
        check("lat1_seq_done_cyc", d_cyc, 10);
        check("lat1_seq_acc", d_acc, 28);
        $display("step: lat3 acc=%0d done_cyc=%0d", d3_acc[31:0], d3_cyc);

        // Start ignored while busy.
        launch(all_digits(5'h01));
        watch(20, 3, 6, 28);
        check("ign_done_cyc", w_done_cyc, 10);
        check("ign_acc", w_acc, 8);
        check("ign_n_done", w_n_done, 1);
        check("ign_en_cnt", w_en, 8);
        $display("step: ignore acc=%0d n_done=%0d", w_acc[31:0], w_n_done);

        // Back-to-back: second start in the DONE cycle.
        rom_mode = 0;
        launch(all_digits(5'h1F));
        watch(9, -1, -1, 8);
        check("b2b_first_done", done, 1);
        check("b2b_first_acc", acc_out, 1116);
        start = 1'b1;
        digits_in = seq_digits();
        @(negedge clk);
        start = 1'b0;
        digits_in = '0;
        cyc = 1;
        check("b2b_busy", busy, 1);
        check("b2b_acc_held", acc_out, 1116);
        watch(10, -1, -1, 1116);
        // sum of (i+1)*i for i=0..7 = 168
        check("b2b_second_cyc", w_done_cyc, 10);
        check("b2b_second_acc", w_acc, 168);
        check("b2b_hold", w_hold_ok, 1);
        $display("step: b2b acc=%0d done_cyc=%0d", w_acc[31:0], w_done_cyc);

        // Reset mid-operation at cycle 5, released at cycle 7.
        launch(all_digits(5'h1F));
        while (cyc < 5) begin
            @(negedge clk);
            cyc++;
        end
        reset = 1'b1;
        #1;
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_acc", acc_out, 0);
        check("mid_rom_en", rom_en, 0);
        check("mid_rom_sel", rom_sel, 0);
        check("mid_rom_addr", rom_addr, 0);
        check("mid_busy3", busy3, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_done_rst = 0;
        for (int i = 0; i < 15; i++) begin
            if (done === 1'b1 || done3 === 1'b1) n_done_rst++;
            @(negedge clk);
        end
        check("mid_no_done", n_done_rst, 0);
        rom_mode = 2;
        launch(seq_digits());
        watch(10, -1, -1, 0);
        check("post_done_cyc", w_done_cyc, 10);
        check("post_acc", w_acc, 28);
        $display("step: post-reset acc=%0d done_cyc=%0d", w_acc[31:0], w_done_cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
